// File: rtl/neotang_clk_pkg.sv
// Shared clocking definitions: PLL sequencer states, counter widths and
// width helpers used by the PLL reset controller and its PLL-domain consumers.
package neotang_clk_pkg;

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_WAIT   = 5'b00010,
        S_STABLE = 5'b00100,
        S_RUN    = 5'b01000,
        S_FAIL   = 5'b10000
    } state_t;

    localparam int unsigned LOSS_CNT_W = 32'd8;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int unsigned clog2_w(input int unsigned value);
        int unsigned w;
        w = 32'd1;
        for (int i = 1; i < 32; i++) begin
            if (value > (32'd1 << i)) begin
                w = i + 32'd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    function automatic int unsigned max3_u(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for level signals crossing into the local clock,
// with asynchronous active-low clear.
module sync_2ff #(
    parameter int unsigned WIDTH = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock monitor running on the board reference clock:
// pulses the PLL reset, qualifies lock, releases the system reset and retries.
module pll_reset_ctrl
    import neotang_clk_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = 32'd16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 32'd65535,
    parameter int unsigned STABLE_CYC       = 32'd1024,
    parameter int unsigned MAX_RETRIES      = 32'd3
) (
    input  logic                  CLKIN,
    input  logic                  RESETN,
    input  logic                  LOCK,
    input  logic                  RESTART,
    output logic                  PLL_RESET,
    output logic                  SYS_RESET_N,
    output logic                  READY,
    output logic                  FAIL,
    output logic [LOSS_CNT_W-1:0] LOSS_CNT
);

    localparam int unsigned CNT_W   = clog2_w(max3_u(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC));
    localparam int unsigned RETRY_W = clog2_w(MAX_RETRIES + 32'd1);

    localparam logic [CNT_W-1:0]      CNT_ZERO    = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]      RST_LAST    = CNT_W'(RST_PULSE_CYC - 32'd1);
    localparam logic [CNT_W-1:0]      WAIT_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 32'd1);
    localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(STABLE_CYC - 32'd1);
    localparam logic [RETRY_W-1:0]    RETRY_ZERO  = RETRY_W'(32'd0);
    localparam logic [RETRY_W-1:0]    RETRY_ONE   = RETRY_W'(32'd1);
    localparam logic [RETRY_W-1:0]    RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE    = LOSS_CNT_W'(32'd1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = {LOSS_CNT_W{1'b1}};

    logic                  lock_s;
    state_t                state_r;
    state_t                next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nx_s;
    logic [RETRY_W-1:0]    retry_r;
    logic [RETRY_W-1:0]    retry_nx_s;
    logic [LOSS_CNT_W-1:0] loss_r;
    logic [LOSS_CNT_W-1:0] loss_nx_s;
    logic                  pll_reset_r;
    logic                  sys_reset_n_r;
    logic                  ready_r;
    logic                  fail_r;

    sync_2ff #(
        .WIDTH(32'd1)
    ) u_lock_sync (
        .clk  (CLKIN),
        .rst_n(RESETN),
        .d    (LOCK),
        .q    (lock_s)
    );

    // Next-state, retry and loss-count decisions; RESTART overrides everything.
    always_comb begin
        next_s     = state_r;
        retry_nx_s = retry_r;
        loss_nx_s  = loss_r;
        if (RESTART) begin
            next_s     = S_RESET;
            retry_nx_s = RETRY_ZERO;
        end else begin
            case (state_r)
                S_RESET: begin
                    if (cnt_r == RST_LAST) begin
                        next_s = S_WAIT;
                    end else begin
                        next_s = S_RESET;
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        next_s = S_STABLE;
                    end else if (cnt_r == WAIT_LAST) begin
                        if (retry_r == RETRY_MAX) begin
                            next_s = S_FAIL;
                        end else begin
                            next_s     = S_RESET;
                            retry_nx_s = retry_r + RETRY_ONE;
                        end
                    end else begin
                        next_s = S_WAIT;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        next_s = S_WAIT;
                    end else if (cnt_r == STABLE_LAST) begin
                        next_s     = S_RUN;
                        retry_nx_s = RETRY_ZERO;
                    end else begin
                        next_s = S_STABLE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        next_s = S_RESET;
                        if (loss_r != LOSS_MAX) begin
                            loss_nx_s = loss_r + LOSS_ONE;
                        end else begin
                            loss_nx_s = loss_r;
                        end
                    end else begin
                        next_s = S_RUN;
                    end
                end
                S_FAIL: begin
                    next_s = S_FAIL;
                end
                default: begin
                    // Illegal encoding: recover through a full PLL reset.
                    next_s     = S_RESET;
                    retry_nx_s = RETRY_ZERO;
                end
            endcase
        end
    end

    // Shared phase counter: restarts on every state change, idles in RUN/FAIL.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (RESTART || (next_s != state_r)) begin
            cnt_nx_s = CNT_ZERO;
        end else if (state_r inside {S_RESET, S_WAIT, S_STABLE}) begin
            cnt_nx_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // State, counters and outputs decoded from next state.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_r       <= S_RESET;
            cnt_r         <= CNT_ZERO;
            retry_r       <= RETRY_ZERO;
            loss_r        <= {LOSS_CNT_W{1'b0}};
            pll_reset_r   <= 1'b1;
            sys_reset_n_r <= 1'b0;
            ready_r       <= 1'b0;
            fail_r        <= 1'b0;
        end else begin
            state_r       <= next_s;
            cnt_r         <= cnt_nx_s;
            retry_r       <= retry_nx_s;
            loss_r        <= loss_nx_s;
            pll_reset_r   <= (next_s == S_RESET) || (next_s == S_FAIL);
            sys_reset_n_r <= (next_s == S_RUN);
            ready_r       <= (next_s == S_RUN);
            fail_r        <= (next_s == S_FAIL);
        end
    end

    assign PLL_RESET   = pll_reset_r;
    assign SYS_RESET_N = sys_reset_n_r;
    assign READY       = ready_r;
    assign FAIL        = fail_r;
    assign LOSS_CNT    = loss_r;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl: expected output vectors are queued with
// the cycle they are due and compared when the DUT reaches that cycle.
module tb_pll_reset_ctrl;

    localparam int RST_CYC = 4;
    localparam int STB_CYC = 8;
    localparam int TO_CYC  = 32;
    localparam int RETRIES = 2;
    localparam int PERIOD  = RST_CYC + TO_CYC;
    localparam int FAIL_AT = (RETRIES + 1) * PERIOD;

    logic       CLKIN;
    logic       RESETN;
    logic       LOCK;
    logic       RESTART;
    logic       PLL_RESET;
    logic       SYS_RESET_N;
    logic       READY;
    logic       FAIL;
    logic [7:0] LOSS_CNT;
    logic [11:0] obs_vec;

    typedef struct {
        string       tag;
        int          due;
        logic [11:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  cyc;
    int  n_vec;
    int  n_err;

    pll_reset_ctrl #(
        .RST_PULSE_CYC   (RST_CYC),
        .LOCK_TIMEOUT_CYC(TO_CYC),
        .STABLE_CYC      (STB_CYC),
        .MAX_RETRIES     (RETRIES)
    ) dut (
        .CLKIN      (CLKIN),
        .RESETN     (RESETN),
        .LOCK       (LOCK),
        .RESTART    (RESTART),
        .PLL_RESET  (PLL_RESET),
        .SYS_RESET_N(SYS_RESET_N),
        .READY      (READY),
        .FAIL       (FAIL),
        .LOSS_CNT   (LOSS_CNT)
    );

    assign obs_vec = {PLL_RESET, SYS_RESET_N, READY, FAIL, LOSS_CNT};

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    function automatic logic [11:0] mk(input logic p, input logic s, input logic r,
                                       input logic f, input logic [7:0] l);
        return {p, s, r, f, l};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int delta, input logic [11:0] exp);
        sb_t e;
        e.tag = tag;
        e.due = cyc + delta;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Advance one edge, sample 1 ns later and retire every entry due now.
    task automatic tick();
        @(posedge CLKIN);
        #1;
        cyc++;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check_eq(sb_q[i].tag, 32'(obs_vec), 32'(sb_q[i].exp));
                sb_q.delete(i);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (!READY && n < limit) begin
            tick();
            n++;
        end
        check_eq("ready_wait", 32'(READY), 32'd1);
    endtask

    // Reset pulse / timeout window pattern with no lock; dd=0 is the edge entering RESET.
    task automatic push_fail_seq(input string tag, input int base, input int first, input int last);
        logic [11:0] e;
        for (int dd = first; dd <= last; dd++) begin
            if (dd >= FAIL_AT) e = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
            else               e = mk(((dd % PERIOD) < RST_CYC), 1'b0, 1'b0, 1'b0, 8'd0);
            sb_push(tag, base + dd, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d expected < 10000", cyc);
        $fatal(1);
    end

    initial begin
        int exp_loss;
        cyc     = 0;
        n_vec   = 0;
        n_err   = 0;
        RESETN  = 1'b0;
        LOCK    = 1'b0;
        RESTART = 1'b0;
        run(3);
        check_eq("reset_state", 32'(obs_vec), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0)));

        // Clean start.
        RESETN = 1'b1;
        for (int d = 1; d < RST_CYC; d++) sb_push("rst_pulse_hi", d, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        sb_push("rst_pulse_end", RST_CYC, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        run(RST_CYC);
        run(10);
        LOCK = 1'b1;
        sb_push("stable_pre", STB_CYC + 2, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        sb_push("sys_release", STB_CYC + 3, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0));
        run(STB_CYC + 4);

        // First lock loss in RUN, exact latency.
        LOCK = 1'b0;
        sb_push("loss_pre", 2, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0));
        sb_push("loss_react", 3, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
        run(3);
        LOCK = 1'b1;
        wait_ready(40);

        // Repeated losses up to and past saturation.
        for (int i = 2; i <= 260; i++) begin
            exp_loss = (i > 255) ? 255 : i;
            LOCK = 1'b0;
            sb_push("loss_cnt", 3, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'(exp_loss)));
            run(3);
            LOCK = 1'b1;
            wait_ready(40);
        end
        check_eq("loss_saturated", 32'(LOSS_CNT), 32'd255);

        // Asynchronous reset between edges while in RUN.
        #3;
        RESETN = 1'b0;
        #1;
        check_eq("async_reset", 32'(obs_vec), 32'(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0)));
        LOCK = 1'b0;
        run(2);

        // Lock bounce during stabilisation, landing on the stable expiry cycle.
        RESETN = 1'b1;
        for (int d = 1; d < RST_CYC; d++) sb_push("b_rst_hi", d, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        sb_push("b_rst_end", RST_CYC, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        run(RST_CYC);
        LOCK = 1'b1;
        for (int d = 1; d <= 21; d++) sb_push("bounce_hold", d, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        sb_push("bounce_release", 22, mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0));
        run(8);
        LOCK = 1'b0;
        run(3);
        LOCK = 1'b1;
        run(11);

        // Timeouts with retries, then FAIL.
        RESETN = 1'b0;
        LOCK   = 1'b0;
        run(2);
        RESETN = 1'b1;
        push_fail_seq("timeout_seq", 0, 1, FAIL_AT + 3);
        run(FAIL_AT + 3);

        // RESTART from FAIL gives a full fresh retry budget.
        RESTART = 1'b1;
        push_fail_seq("restart_fail", 1, 0, FAIL_AT + 3);
        tick();
        RESTART = 1'b0;
        run(FAIL_AT + 3);

        // RESTART coinciding with the second timeout expiry.
        RESTART = 1'b1;
        push_fail_seq("restart_run", 1, 0, 2 * PERIOD - 1);
        tick();
        RESTART = 1'b0;
        run(2 * PERIOD - 1);
        RESTART = 1'b1;
        push_fail_seq("restart_expiry", 1, 0, FAIL_AT + 3);
        tick();
        RESTART = 1'b0;
        run(FAIL_AT + 3);

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
